// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared definitions for the UART transmit arbiter. Holds the
//                FSM state encoding, the upper limits of GUARD_CYCLES and
//                BUSY_TIMEOUT, and the width of the shared cycle counter.
//  Config      : none here. UART_ARB_FIXED_PRIO_EN is consumed by
//                uart_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GUARD     = 3'd4
   } arb_state_t;

   localparam int GUARD_CYCLES_MAX = 255;
   localparam int BUSY_TIMEOUT_MAX = 255;

   // One counter serves both the busy timeout and the guard gap. It must
   // hold the larger of the two maxima.
   localparam int CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_picker
//  Description : Rotating-priority picker. The search starts at index ptr and
//                wraps modulo N_REQ. The first set bit of valid wins.
//                Tying ptr to zero turns it into a fixed lowest-index-first
//                picker.
//  Ports       : valid [N_REQ-1:0]  request vector
//                ptr   [IDX_W-1:0]  index that has the highest priority
//                grant [N_REQ-1:0]  one-hot winner (zero when none)
//                idx   [IDX_W-1:0]  winner index (zero when none)
//                any                at least one request is valid
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int               w_sum;
   logic [IDX_W-1:0] w_cand;

   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      w_sum  = 0;
      w_cand = '0;
      for (int off = 0; off < N_REQ; off++) begin
         // ptr is always below N_REQ, so one subtraction is enough to wrap.
         w_sum = int'(ptr) + off;
         if (w_sum >= N_REQ) begin
            w_sum = w_sum - N_REQ;
         end
         w_cand = IDX_W'(w_sum);
         if (!any && valid[w_cand]) begin
            any           = 1'b1;
            idx           = w_cand;
            grant[w_cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Arbitrates N_REQ byte requesters onto a single uart_tx.
//                It picks one requester while idle, pulses tx_en, waits for
//                the transmitter to go busy and then idle again, and keeps a
//                guard gap before the next frame.
//  Config      : `define UART_ARB_FIXED_PRIO_EN selects fixed priority, where
//                the lowest valid index wins. The default is round-robin.
//  Ports       : sys_clk, sys_rst             clock, async active-high reset
//                req_valid/req_data/req_ready requester handshake, bytes packed
//                                             8 bits per requester
//                tx_busy/tx_en/tx_din         uart_tx interface
//                grant_id                     owner of the current frame
//                arb_busy                     FSM not in IDLE
//                tx_err                       one-cycle busy-timeout pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int GUARD_CYCLES = 2,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [8*N_REQ-1:0]         req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       tx_busy,
   output logic                       tx_en,
   output logic [7:0]                 tx_din,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       arb_busy,
   output logic                       tx_err
);

   localparam int IDX_W = $clog2(N_REQ);

   // Clamp the parameters to the range the counter can represent.
   localparam int c_guard_eff = (GUARD_CYCLES > GUARD_CYCLES_MAX) ? GUARD_CYCLES_MAX :
                                (GUARD_CYCLES < 0) ? 0 : GUARD_CYCLES;
   localparam int c_busy_eff  = (BUSY_TIMEOUT > BUSY_TIMEOUT_MAX) ? BUSY_TIMEOUT_MAX :
                                (BUSY_TIMEOUT < 1) ? 1 : BUSY_TIMEOUT;

   localparam logic [CNT_W-1:0] c_busy_last  = CNT_W'(c_busy_eff - 1);
   localparam logic [CNT_W-1:0] c_guard_last = CNT_W'((c_guard_eff > 0) ? c_guard_eff - 1 : 0);
   // With a zero guard, the FSM returns to IDLE straight from the frame end.
   localparam logic             c_guard_skip = (c_guard_eff == 0);

   arb_state_t       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             tx_en_q,    tx_en_d;
   logic             tx_err_q,   tx_err_d;
   logic             arb_busy_q, arb_busy_d;
   logic [7:0]       tx_din_q,   tx_din_d;
   logic [IDX_W-1:0] grant_id_q, grant_id_d;

   logic [N_REQ-1:0] w_pick_grant;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic [IDX_W-1:0] w_ptr;
   logic             w_grant_ok;

`ifdef UART_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   // ptr_q holds the index with the highest priority for the next search,
   // which is the last winner + 1. A reset value of 0 favours requester 0.
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] w_next_ptr;

   assign w_ptr      = ptr_q;
   assign w_next_ptr = (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
`endif

   uart_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .valid (req_valid),
      .ptr   (w_ptr),
      .grant (w_pick_grant),
      .idx   (w_pick_idx),
      .any   (w_pick_any)
   );

   // A grant happens only in IDLE while the transmitter is free.
   assign w_grant_ok = (state_q == ST_IDLE) && !tx_busy && w_pick_any;

   // The acceptance strobe is combinational. It is also gated by reset so that
   // it is zero while reset is held.
   assign req_ready = (w_grant_ok && !sys_rst) ? w_pick_grant : '0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_err_d   = 1'b0;
      tx_din_d   = tx_din_q;
      grant_id_d = grant_id_q;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr_d      = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_grant_ok) begin
               state_d    = ST_LAUNCH;
               tx_din_d   = req_data[{w_pick_idx, 3'b000} +: 8];
               grant_id_d = w_pick_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
               ptr_d      = w_next_ptr;
`endif
            end
         end
         ST_LAUNCH: begin
            // The count includes the launch cycle. The error pulse, which is
            // registered, then lands exactly BUSY_TIMEOUT cycles after tx_en.
            state_d = ST_WAIT_BUSY;
            cnt_d   = CNT_W'(1);
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
               cnt_d   = '0;
            end else if (cnt_q >= c_busy_last) begin
               tx_err_d = 1'b1;
               state_d  = c_guard_skip ? ST_IDLE : ST_GUARD;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = c_guard_skip ? ST_IDLE : ST_GUARD;
               cnt_d   = '0;
            end
         end
         ST_GUARD: begin
            if (cnt_q >= c_guard_last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      tx_en_d    = (state_d == ST_LAUNCH);
      arb_busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         tx_en_q    <= 1'b0;
         tx_err_q   <= 1'b0;
         arb_busy_q <= 1'b0;
         tx_din_q   <= '0;
         grant_id_q <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
         ptr_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_en_q    <= tx_en_d;
         tx_err_q   <= tx_err_d;
         arb_busy_q <= arb_busy_d;
         tx_din_q   <= tx_din_d;
         grant_id_q <= grant_id_d;
`ifndef UART_ARB_FIXED_PRIO_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   assign tx_en    = tx_en_q;
   assign tx_err   = tx_err_q;
   assign arb_busy = arb_busy_q;
   assign tx_din   = tx_din_q;
   assign grant_id = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter. The
//                u_dut instance uses the default parameters. The u_dut0
//                instance uses GUARD_CYCLES=0. A uart_tx responder model
//                raises tx_busy one cycle after tx_en and holds it for
//                BUSY_LEN cycles. A scoreboard holds the expected
//                {grant_id, tx_din} pair for each launched frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int BUSY_LEN = 20;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [3:0]  req_valid0, req_valid1;
   logic [31:0] req_data0,  req_data1;
   logic [3:0]  req_ready0, req_ready1;
   logic        tx_busy0,   tx_busy1;
   logic        tx_en0,     tx_en1;
   logic [7:0]  tx_din0,    tx_din1;
   logic [1:0]  grant_id0,  grant_id1;
   logic        arb_busy0,  arb_busy1;
   logic        tx_err0,    tx_err1;
   logic        ext_busy0;

   logic        m_busy [2];
   int          m_left [2];
   bit          m_pend [2];
   int          m_mode [2];   // 0: normal responder, 1: never raises busy

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          en_cnt0 = 0, en_cyc0 = 0, err_cnt0 = 0;
   int          en_cnt1 = 0, en_cyc1 = 0;
   logic [15:0] sb [$];
   logic [15:0] sb_e;

   always #5 sys_clk = ~sys_clk;

   assign tx_busy0 = m_busy[0] | ext_busy0;
   assign tx_busy1 = m_busy[1];

   uart_tx_arbiter #(
      .N_REQ        (4),
      .GUARD_CYCLES (2),
      .BUSY_TIMEOUT (16)
   ) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .req_valid (req_valid0),
      .req_data  (req_data0),
      .req_ready (req_ready0),
      .tx_busy   (tx_busy0),
      .tx_en     (tx_en0),
      .tx_din    (tx_din0),
      .grant_id  (grant_id0),
      .arb_busy  (arb_busy0),
      .tx_err    (tx_err0)
   );

   uart_tx_arbiter #(
      .N_REQ        (4),
      .GUARD_CYCLES (0),
      .BUSY_TIMEOUT (16)
   ) u_dut0 (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .req_valid (req_valid1),
      .req_data  (req_data1),
      .req_ready (req_ready1),
      .tx_busy   (tx_busy1),
      .tx_en     (tx_en1),
      .tx_din    (tx_din1),
      .grant_id  (grant_id1),
      .arb_busy  (arb_busy1),
      .tx_err    (tx_err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic wait_idle0();
      for (int i = 0; i < 200 && arb_busy0; i++) step();
      check("idle_reached", 32'(arb_busy0), 32'd0);
   endtask

   task automatic wait_en0(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && en_cnt0 < target; i++) step();
      check(tag, 32'(en_cnt0), 32'(target));
   endtask

   task automatic do_reset();
      step();
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      step();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_tx_en"},     32'(tx_en0),     32'd0);
      check({tag, "_tx_err"},    32'(tx_err0),    32'd0);
      check({tag, "_arb_busy"},  32'(arb_busy0),  32'd0);
      check({tag, "_req_ready"}, 32'(req_ready0), 32'd0);
      check({tag, "_tx_din"},    32'(tx_din0),    32'd0);
      check({tag, "_grant_id"},  32'(grant_id0),  32'd0);
   endtask

   always @(posedge sys_clk) cyc <= cyc + 1;

   // uart_tx responder: busy rises one cycle after tx_en and lasts BUSY_LEN cycles.
   initial begin
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         m_left[k] = 0;
         m_pend[k] = 1'b0;
         m_mode[k] = 0;
      end
      forever begin
         @(posedge sys_clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (m_left[k] > 0) begin
               m_left[k]--;
               if (m_left[k] == 0) m_busy[k] = 1'b0;
            end
            if (m_pend[k]) begin
               m_pend[k] = 1'b0;
               m_busy[k] = 1'b1;
               m_left[k] = BUSY_LEN;
            end
            if (((k == 0) ? tx_en0 : tx_en1) && m_mode[k] == 0) m_pend[k] = 1'b1;
         end
      end
   end

   // Frame monitor: every launch of u_dut must match the next scoreboard entry.
   always @(negedge sys_clk) begin
      if (tx_en0) begin
         en_cnt0++;
         en_cyc0 = cyc;
         check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            sb_e = sb.pop_front();
            check("grant_id", 32'(grant_id0), 32'(sb_e[15:8]));
            check("tx_din",   32'(tx_din0),   32'(sb_e[7:0]));
         end
      end
      if (tx_err0) err_cnt0++;
      if (tx_en1) begin
         en_cnt1++;
         en_cyc1 = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed time limit expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, t_en, e0, f_cyc;
      sys_rst    = 1'b1;
      req_valid0 = 4'b0001;
      req_valid1 = '0;
      req_data0  = '0;
      req_data1  = '0;
      ext_busy0  = 1'b0;
      repeat (3) step();

      // Reset state. A pending request must not raise req_ready while reset is held.
      check_outputs_zero("reset");
      req_valid0 = '0;
      sys_rst    = 1'b0;
      step();

      // Single requester 0, byte A5.
      req_data0[7:0] = 8'hA5;
      req_valid0     = 4'b0001;
      sb.push_back({8'd0, 8'hA5});
      #1;
      check("req_ready_idle", 32'(req_ready0), 32'h1);
      step();
      check("launch_latency", 32'(tx_en0), 32'd1);
      check("launch_count", 32'(en_cnt0), 32'd1);
      req_valid0 = '0;
      step();
      check("tx_en_one_cycle", 32'(tx_en0), 32'd0);
      check("req_ready_busy", 32'(req_ready0), 32'd0);
      wait_idle0();
      check("frame_once", 32'(en_cnt0), 32'd1);
      check("tx_din_held", 32'(tx_din0), 32'hA5);
      check("no_err_normal", 32'(err_cnt0), 32'd0);

      // All four requesting for eight frames.
      do_reset();
      req_data0  = 32'h13121110;
      req_valid0 = 4'b1111;
      base       = en_cnt0;
      for (int i = 0; i < 8; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
         sb.push_back({8'd0, 8'h10});
`else
         sb.push_back({8'(i % 4), 8'h10 + 8'(i % 4)});
`endif
      end
      wait_en0(base + 8, 400, "eight_frames");
      req_valid0 = '0;
      check("sb_drained", 32'(sb.size()), 32'd0);
      wait_idle0();

      // Transmitter that never goes busy.
      m_mode[0]       = 1;
      req_data0[15:8] = 8'h5C;
      req_valid0      = 4'b0010;
      sb.push_back({8'd1, 8'h5C});
      base = en_cnt0;
      e0   = err_cnt0;
      wait_en0(base + 1, 10, "timeout_launch");
      req_valid0 = '0;
      t_en       = en_cyc0;
      for (int i = 0; i < 40 && !tx_err0; i++) step();
      check("tx_err_pulse", 32'(tx_err0), 32'd1);
      check("tx_err_delay", 32'(cyc - t_en), 32'd16);
      step();
      check("tx_err_one_cycle", 32'(tx_err0), 32'd0);
      for (int i = 0; i < 40 && arb_busy0; i++) step();
      check("idle_after_guard", 32'(cyc - t_en), 32'd18);
      check("tx_err_count", 32'(err_cnt0 - e0), 32'd1);
      m_mode[0] = 0;

      // Reset during WAIT_DONE.
      req_data0[23:16] = 8'h77;
      req_valid0       = 4'b0100;
      sb.push_back({8'd2, 8'h77});
      base = en_cnt0;
      wait_en0(base + 1, 10, "rst_frame_launch");
      req_valid0 = '0;
      for (int i = 0; i < 10 && !tx_busy0; i++) step();
      repeat (3) step();
      check("in_wait_done", 32'(arb_busy0), 32'd1);
      e0         = err_cnt0;
      req_data0  = 32'hD3D2D1D0;
      req_valid0 = 4'b1111;
      sys_rst    = 1'b1;
      #1;
      check_outputs_zero("async_rst");
      step();
      step();
      check("no_err_on_reset", 32'(err_cnt0 - e0), 32'd0);
      sys_rst = 1'b0;
      sb.push_back({8'd0, 8'hD0});
      base = en_cnt0;
      wait_en0(base + 1, 60, "post_reset_grant");
      req_valid0 = '0;
      wait_idle0();

      // Busy driven externally: no grant until it drops.
      ext_busy0        = 1'b1;
      req_data0[23:16] = 8'h3C;
      req_valid0       = 4'b0100;
      sb.push_back({8'd2, 8'h3C});
      base = en_cnt0;
      repeat (5) begin
         step();
         check("ext_busy_no_ready", 32'(req_ready0), 32'd0);
      end
      check("ext_busy_no_launch", 32'(en_cnt0 - base), 32'd0);
      ext_busy0 = 1'b0;
      #1;
      check("ready_after_busy_falls", 32'(req_ready0), 32'h4);
      step();
      check("grant_after_busy_falls", 32'(en_cnt0 - base), 32'd1);
      req_valid0 = '0;
      wait_idle0();

      // Zero guard, back-to-back frames on u_dut0.
      req_data1[7:0] = 8'h11;
      req_valid1     = 4'b0001;
      for (int i = 0; i < 10 && en_cnt1 < 1; i++) step();
      check("g0_first_launch", 32'(en_cnt1), 32'd1);
      for (int i = 0; i < 10 && !tx_busy1; i++) step();
      for (int i = 0; i < 40 && tx_busy1; i++) step();
      f_cyc = cyc;
      check("g0_busy_fell", 32'(tx_busy1), 32'd0);
      for (int i = 0; i < 10 && en_cnt1 < 2; i++) step();
      req_valid1 = '0;
      check("g0_second_launch", 32'(en_cnt1), 32'd2);
      check("g0_gap", 32'(en_cyc1 - f_cyc), 32'd2);
      check("g0_tx_din", 32'(tx_din1), 32'h11);
      check("g0_grant_id", 32'(grant_id1), 32'd0);

      check("sb_final_empty", 32'(sb.size()), 32'd0);
      check("total_tx_err", 32'(err_cnt0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of byte requesters (2..8).
REQ-002 SHALL have parameter GUARD_CYCLES, default 2, meaning idle sys_clk cycles enforced between frames (0..255).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16, meaning cycles allowed for tx_busy to rise after tx_en (1..255).
REQ-004 SHALL have port sys_clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port sys_rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  requester i has a byte pending.
REQ-007 SHALL have port req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot accept; byte i is taken when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port tx_busy  input  1  transmitter busy flag from uart_tx.
REQ-010 SHALL have port tx_en  output  1  one-cycle launch pulse to uart_tx.
REQ-011 SHALL have port tx_din  output  8  byte to uart_tx.
REQ-012 SHALL have port grant_id  output  clog2(N_REQ)  index of the requester owning the current frame.
REQ-013 SHALL have port arb_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port tx_err  output  1  one-cycle pulse on busy timeout.

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GUARD.
REQ-016 IDLE: when any req_valid is high and tx_busy is low, SHALL assert req_ready for exactly the winning index (combinational in IDLE only), capture its byte into tx_din, latch grant_id, and go to LAUNCH.
REQ-017 IDLE with tx_busy high (external use) SHALL grant nothing and SHALL stay in IDLE.
REQ-018 LAUNCH SHALL assert tx_en for exactly one cycle and go to WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on tx_busy high; after BUSY_TIMEOUT cycles without tx_busy high it SHALL pulse tx_err and go to GUARD.
REQ-020 WAIT_DONE SHALL go to GUARD on tx_busy low.
REQ-021 GUARD SHALL count GUARD_CYCLES cycles and then go to IDLE; GUARD_CYCLES=0 SHALL return to IDLE on the next cycle.
REQ-022 tx_din and grant_id SHALL be held stable from capture until the next grant.
REQ-023 Default arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_REQ, and the pointer updates only on a grant.
REQ-024 A requester dropping req_valid before grant SHALL lose nothing; a granted byte SHALL be transmitted exactly once.
REQ-025 Latency from req_valid (FSM in IDLE, tx_busy low) to tx_en SHALL be exactly 1 cycle.
REQ-026 req_ready SHALL be all-zero in every non-IDLE state.

Reset
REQ-027 On sys_rst high, the FSM SHALL enter IDLE immediately, regardless of the current state.
REQ-028 On sys_rst high, the round-robin pointer SHALL be set so that index 0 has highest priority.
REQ-029 On sys_rst high, tx_en, tx_err, arb_busy, req_ready, tx_din, grant_id and the counters SHALL all be 0.
REQ-030 Reset mid-frame SHALL abandon the frame without a tx_err pulse.

Configuration
REQ-031 With macro UART_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest valid index wins, pointer unused); when undefined, arbitration SHALL be round-robin per REQ-023.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the FSM state encoding and the maximum values for GUARD_CYCLES and BUSY_TIMEOUT.
REQ-033 The arbitration SHALL be implemented as sub-module uart_rr_picker (inputs: valid vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-034 Bench SHALL drive req_valid=4'b0001, req_data[7:0]=8'hA5 and a uart_tx model raising tx_busy 1 cycle after tx_en for 20 cycles -> tx_en 1 cycle after grant, tx_din=8'hA5, grant_id=0.
REQ-035 Bench SHALL hold req_valid=4'b1111 for 8 frames -> grant order 0,1,2,3,0,1,2,3 (macro defined: eight grants to 0).
REQ-036 Bench SHALL use a model that never raises tx_busy with BUSY_TIMEOUT=16 -> tx_err pulse 16 cycles after tx_en, then IDLE after the GUARD wait.
REQ-037 Bench SHALL assert sys_rst during WAIT_DONE -> all outputs 0 asynchronously, no tx_err, next grant to index 0.
REQ-038 Bench SHALL hold tx_busy high externally with req_valid=4'b0100 -> req_ready stays 0 until tx_busy falls, then grant 2.
REQ-039 Bench SHALL set GUARD_CYCLES=0 with back-to-back requests -> next tx_en exactly 2 cycles after tx_busy falls.
